// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//
// Runs the audio analysis path one frame at a time. A frame triggers an audio
// RAM load, starts the FFT controller, then reads FFT power RAM bins 1..LEN/2-1
// to find the peak bin. The DC bin and the mirror half are not read. The power
// RAM has one read port, which is shared between this scanner and the host.
//
// Handshake semantics: none of the interfaces is valid/ready. oLoadStart and
// oFftStart are single-cycle request pulses. iLoadComplete and iFftDone are
// accepted only on a 0->1 transition seen while waiting for them, so a level
// that was already high does not count. oFrameReady is a single-cycle pulse
// in the cycle where the peak outputs first show the new frame.
//
// Ports
//   iStateClk      clock; every input is synchronous to it
//   iReset         asynchronous, active-high reset
//   iEnable        level: run frames back to back
//   iHostReq       pulse: from IDLE, run one frame and clear oError
//   iThreshold     power threshold that drives oSound
//   oLoadStart     pulse to the audio RAM controller
//   iLoadComplete  load complete from the audio RAM controller
//   oFftStart      pulse to the FFT controller
//   iFftDone       FFT done from the FFT controller
//   oFftAddr       power RAM read address (scanner or host)
//   iFftPower      power RAM read data, RD_LAT cycles after the address
//   iFftExp        block exponent, same timing as iFftPower
//   iHostAddr      host read address
//   oHostBusy      1 while the scanner owns the power RAM port
//   oPeakBin       peak bin of the last completed frame
//   oPeakPower     power at oPeakBin
//   oPeakExp       exponent captured with the peak
//   oSound         oPeakPower >= iThreshold, sampled at frame end
//   oFrameReady    single-cycle strobe when the peak outputs update
//   oFrameCount    count of completed frames (wraps)
//   oBusy          FSM is not in IDLE
//   oError         sticky watchdog timeout flag
//   oState         debug view of the FSM state
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
  parameter int LEN     = 1024,
  parameter int LBITS   = 10,
  parameter int BITS    = 16,
  parameter int EBITS   = 6,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 2**20
) (
  input  logic             iStateClk,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iHostReq,
  input  logic [BITS-1:0]  iThreshold,
  output logic             oLoadStart,
  input  logic             iLoadComplete,
  output logic             oFftStart,
  input  logic             iFftDone,
  output logic [LBITS-1:0] oFftAddr,
  input  logic [BITS-1:0]  iFftPower,
  input  logic [EBITS-1:0] iFftExp,
  input  logic [LBITS-1:0] iHostAddr,
  output logic             oHostBusy,
  output logic [LBITS-1:0] oPeakBin,
  output logic [BITS-1:0]  oPeakPower,
  output logic [EBITS-1:0] oPeakExp,
  output logic             oSound,
  output logic             oFrameReady,
  output logic [15:0]      oFrameCount,
  output logic             oBusy,
  output logic             oError,
  output logic [2:0]       oState
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_FFT_START = 3'd3,
    S_FFT_WAIT  = 3'd4,
    S_SCAN      = 3'd5,
    S_DRAIN     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [LBITS-1:0] FIRST_BIN  = LBITS'(1);
  localparam logic [LBITS-1:0] LAST_BIN   = LBITS'(LEN / 2 - 1);
  localparam logic [WDW-1:0]   WD_LAST    = WDW'(TIMEOUT - 1);
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(RD_LAT - 1);

  state_t state, state_nxt;

  logic             load_prev, done_prev;
  logic [WDW-1:0]   wd_cnt;
  logic [LBITS-1:0] scan_addr;
  logic [DCW-1:0]   drain_cnt;
  logic             vld_sr [RD_LAT];
  logic [LBITS-1:0] bin_sr [RD_LAT];
  logic             have_max;
  logic [LBITS-1:0] max_bin;
  logic [BITS-1:0]  max_pwr;
  logic [EBITS-1:0] max_exp;

  logic             load_rise, fft_rise, wd_expired, timeout;
  logic             take_sample, drain_end;
  logic [LBITS-1:0] cand_bin;
  logic [BITS-1:0]  cand_pwr;
  logic [EBITS-1:0] cand_exp;

  assign load_rise  = iLoadComplete & ~load_prev;
  assign fft_rise   = iFftDone & ~done_prev;
  assign wd_expired = (wd_cnt == WD_LAST);
  assign drain_end  = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

  // The tail of the shift register marks the cycle where iFftPower belongs to
  // bin_sr's tail. Strict '>' keeps the lowest bin when several bins tie.
  assign take_sample = vld_sr[RD_LAT-1] && (!have_max || (iFftPower > max_pwr));
  assign cand_bin    = take_sample ? bin_sr[RD_LAT-1] : max_bin;
  assign cand_pwr    = take_sample ? iFftPower        : max_pwr;
  assign cand_exp    = take_sample ? iFftExp          : max_exp;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      S_IDLE:      if (iEnable || iHostReq) state_nxt = S_LOAD_REQ;
      S_LOAD_REQ:  state_nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (load_rise) begin
          state_nxt = S_FFT_START;
        end else if (wd_expired) begin
          state_nxt = S_IDLE;
          timeout   = 1'b1;
        end
      end
      S_FFT_START: state_nxt = S_FFT_WAIT;
      S_FFT_WAIT: begin
        if (fft_rise) begin
          state_nxt = S_SCAN;
        end else if (wd_expired) begin
          state_nxt = S_IDLE;
          timeout   = 1'b1;
        end
      end
      S_SCAN:      if (scan_addr == LAST_BIN) state_nxt = S_DRAIN;
      S_DRAIN:     if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:      state_nxt = iEnable ? S_LOAD_REQ : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iStateClk or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Outputs decoded from the state
  assign oLoadStart  = (state == S_LOAD_REQ);
  assign oFftStart   = (state == S_FFT_START);
  assign oHostBusy   = (state == S_SCAN) || (state == S_DRAIN);
  assign oFrameReady = (state == S_DONE);
  assign oBusy       = (state != S_IDLE);
  assign oFftAddr    = oHostBusy ? scan_addr : iHostAddr;
  assign oState      = state;

  // Datapath: edge detect, watchdog, scan counter, read pipeline, running max
  always_ff @(posedge iStateClk or posedge iReset) begin
    if (iReset) begin
      load_prev   <= 1'b0;
      done_prev   <= 1'b0;
      wd_cnt      <= '0;
      scan_addr   <= '0;
      drain_cnt   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        vld_sr[i] <= 1'b0;
        bin_sr[i] <= '0;
      end
      have_max    <= 1'b0;
      max_bin     <= '0;
      max_pwr     <= '0;
      max_exp     <= '0;
      oPeakBin    <= '0;
      oPeakPower  <= '0;
      oPeakExp    <= '0;
      oSound      <= 1'b0;
      oFrameCount <= '0;
      oError      <= 1'b0;
    end else begin
      load_prev <= iLoadComplete;
      done_prev <= iFftDone;

      // The watchdog is cleared in the state just before each wait state.
      if ((state == S_LOAD_REQ) || (state == S_FFT_START))
        wd_cnt <= '0;
      else if ((state == S_LOAD_WAIT) || (state == S_FFT_WAIT))
        wd_cnt <= wd_cnt + WDW'(1);

      if (state == S_FFT_WAIT)
        scan_addr <= FIRST_BIN;
      else if ((state == S_SCAN) && (scan_addr != LAST_BIN))
        scan_addr <= scan_addr + LBITS'(1);

      if (state == S_SCAN)       drain_cnt <= '0;
      else if (state == S_DRAIN) drain_cnt <= drain_cnt + DCW'(1);

      vld_sr[0] <= (state == S_SCAN);
      bin_sr[0] <= scan_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        bin_sr[i] <= bin_sr[i-1];
      end

      if (state == S_FFT_WAIT) begin
        have_max <= 1'b0;
      end else if (take_sample) begin
        have_max <= 1'b1;
        max_bin  <= bin_sr[RD_LAT-1];
        max_pwr  <= iFftPower;
        max_exp  <= iFftExp;
      end

      // The last sample arrives in the final drain cycle. The cand_* values
      // already include it, so the outputs are loaded while entering DONE.
      if (drain_end) begin
        oPeakBin    <= cand_bin;
        oPeakPower  <= cand_pwr;
        oPeakExp    <= cand_exp;
        oSound      <= (cand_pwr >= iThreshold);
        oFrameCount <= oFrameCount + 16'd1;
      end

      if (timeout)
        oError <= 1'b1;
      else if ((state == S_IDLE) && iHostReq)
        oError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
//
// Directed bench for fft_frame_sequencer. It contains a power RAM model,
// responders for the load controller and the FFT controller, and a peak model
// that finds the expected peak from the RAM contents. A compare process checks
// the DUT on every falling edge. The main sequence adds literal checks.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

  localparam int LEN       = 1024;
  localparam int LBITS     = 10;
  localparam int BITS      = 16;
  localparam int EBITS     = 6;
  localparam int RD_LAT    = 2;
  localparam int TIMEOUT   = 400;
  localparam int W         = LBITS + BITS + EBITS;
  localparam int LOAD_DLY  = 50;
  localparam int FFT_DLY   = 200;
  localparam int FRAME_MAX = 2000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             iReset, iEnable, iHostReq;
  logic [BITS-1:0]  iThreshold;
  logic             oLoadStart, iLoadComplete, oFftStart, iFftDone;
  logic [LBITS-1:0] oFftAddr, iHostAddr, oPeakBin;
  logic [BITS-1:0]  iFftPower, oPeakPower;
  logic [EBITS-1:0] iFftExp, oPeakExp;
  logic             oHostBusy, oSound, oFrameReady, oBusy, oError;
  logic [15:0]      oFrameCount;
  logic [2:0]       oState;

  fft_frame_sequencer #(
    .LEN(LEN), .LBITS(LBITS), .BITS(BITS), .EBITS(EBITS),
    .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .iStateClk(clk), .iReset(iReset), .iEnable(iEnable), .iHostReq(iHostReq),
    .iThreshold(iThreshold), .oLoadStart(oLoadStart), .iLoadComplete(iLoadComplete),
    .oFftStart(oFftStart), .iFftDone(iFftDone), .oFftAddr(oFftAddr),
    .iFftPower(iFftPower), .iFftExp(iFftExp), .iHostAddr(iHostAddr),
    .oHostBusy(oHostBusy), .oPeakBin(oPeakBin), .oPeakPower(oPeakPower),
    .oPeakExp(oPeakExp), .oSound(oSound), .oFrameReady(oFrameReady),
    .oFrameCount(oFrameCount), .oBusy(oBusy), .oError(oError), .oState(oState)
  );

  // power RAM model with a two-cycle read latency
  logic [BITS-1:0]  pwr [LEN];
  logic [EBITS-1:0] ex  [LEN];
  logic [LBITS-1:0] a_d1, a_d2;
  always @(posedge clk) begin
    a_d1 <= oFftAddr;
    a_d2 <= a_d1;
  end
  assign iFftPower = pwr[a_d2];
  assign iFftExp   = ex[a_d2];

  // load / FFT responders
  logic load_pulse = 1'b0, load_hold = 1'b0, load_resp_en = 1'b1;
  logic fft_pulse = 1'b0;
  assign iLoadComplete = load_pulse | load_hold;
  assign iFftDone      = fft_pulse;

  initial forever begin
    @(posedge clk); #1;
    if (oLoadStart && load_resp_en) begin
      repeat (LOAD_DLY) @(posedge clk);
      #1 load_pulse = 1'b1;
      @(posedge clk); #1 load_pulse = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (oFftStart) begin
      repeat (FFT_DLY) @(posedge clk);
      #1 fft_pulse = 1'b1;
      @(posedge clk); #1 fft_pulse = 1'b0;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Peak model: over bins 1..LEN/2-1, the first bin with the largest power.
  function automatic logic [W-1:0] model_peak();
    int best = 1;
    for (int b = 2; b < LEN / 2; b++)
      if (pwr[b] > pwr[best]) best = b;
    return {LBITS'(best), pwr[best], ex[best]};
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_peak = '0;
  logic         last_sound = 1'b0;
  logic [15:0]  model_count = '0;
  int busy_run = 0, last_busy_len = 0, n_load = 0, n_fft = 0;

  always @(negedge clk) begin
    if (iReset) begin
      exp_q.delete();
      last_peak   = '0;
      last_sound  = 1'b0;
      model_count = '0;
      busy_run    = 0;
      check("rst_ctrl", {oLoadStart, oFftStart, oHostBusy, oSound, oFrameReady, oBusy, oError}, 0);
      check("rst_peak", {oPeakBin, oPeakPower, oPeakExp, oFrameCount}, 0);
      check("rst_addr", oFftAddr, iHostAddr);
    end else begin
      if (oLoadStart) n_load++;
      if (oFftStart) begin
        n_fft++;
        exp_q.push_back(model_peak());
      end
      if (oHostBusy) begin
        busy_run++;
        if (busy_run <= LEN / 2 - 1) check("scan_addr", oFftAddr, busy_run);
      end else begin
        if (busy_run != 0) begin
          check("busy_len", busy_run, LEN / 2 - 1 + RD_LAT);
          last_busy_len = busy_run;
          busy_run = 0;
        end
        check("host_addr", oFftAddr, iHostAddr);
      end
      if (oFrameReady) begin
        if (exp_q.size() == 0) begin
          check("ready_expected", 1, 0);
        end else begin
          last_peak   = exp_q.pop_front();
          last_sound  = (last_peak[BITS+EBITS-1:EBITS] >= iThreshold);
          model_count = model_count + 16'd1;
        end
      end
      check("peak", {oPeakBin, oPeakPower, oPeakExp}, last_peak);
      check("sound", oSound, last_sound);
      check("frame_count", oFrameCount, model_count);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_host();
    iHostReq = 1'b1;
    tick(1);
    iHostReq = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < FRAME_MAX && !ok; i++) begin
      @(negedge clk);
      if (oFrameReady) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  task automatic wait_sig(input string name, input int which, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if ((which == 0 && oFftStart) || (which == 1 && oHostBusy) || (which == 2 && oError))
        ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int l0, f0;
    logic [15:0] c0;

    iReset = 1'b1; iEnable = 1'b0; iHostReq = 1'b0;
    iThreshold = 16'h3FFF; iHostAddr = 10'h155;
    for (int i = 0; i < LEN; i++) begin
      pwr[i] = 16'h0100;
      ex[i]  = EBITS'(i % 64);
    end
    pwr[0] = 16'hFFFF; pwr[37] = 16'h4000; pwr[300] = 16'h4000;
    pwr[512] = 16'hFFFF; pwr[700] = 16'hFFFF;
    tick(3);
    check("rst_fftaddr", oFftAddr, 10'h155);
    iReset = 1'b0;
    tick(2);

    // Single host frame; a host request during the frame must be ignored.
    iHostAddr = 10'd5;
    tick(1);
    check("host_addr5", oFftAddr, 10'd5);
    pulse_host();
    tick(100);
    pulse_host();
    wait_ready("ready_1");
    check("f1_bin", oPeakBin, 10'd37);
    check("f1_pwr", oPeakPower, 16'h4000);
    check("f1_exp", oPeakExp, 6'd37);
    check("f1_sound", oSound, 1'b1);
    check("f1_count", oFrameCount, 16'd1);
    tick(2);
    check("f1_idle", oBusy, 1'b0);
    check("f1_loads", n_load, 1);
    check("f1_ffts", n_fft, 1);
    check("f1_busy_len", last_busy_len, 513);
    check("f1_hostaddr_back", oFftAddr, 10'd5);

    // The threshold is above the peak, so oSound must be 0.
    iThreshold = 16'h4001; iHostAddr = 10'd77;
    pulse_host();
    wait_ready("ready_2");
    check("f2_sound", oSound, 1'b0);

    // Boundary bins 1 and 511 tie: the lowest bin wins.
    pwr[1] = 16'h7000; pwr[511] = 16'h7000;
    tick(1);
    pulse_host();
    wait_ready("ready_3");
    check("f3_bin", oPeakBin, 10'd1);
    check("f3_exp", oPeakExp, 6'd1);

    // Only the last bin holds the peak. The threshold equals the peak.
    pwr[1] = 16'h0100; iThreshold = 16'h7000;
    tick(1);
    pulse_host();
    wait_ready("ready_4");
    check("f4_bin", oPeakBin, 10'd511);
    check("f4_exp", oPeakExp, 6'd63);
    check("f4_sound", oSound, 1'b1);
    tick(2);

    // Enable runs three frames; it drops during the third FFT wait.
    l0 = n_load; f0 = n_fft; c0 = oFrameCount;
    iEnable = 1'b1;
    wait_ready("en_ready_1");
    wait_ready("en_ready_2");
    wait_sig("en_fft_3", 0, FRAME_MAX);
    tick(20);
    iEnable = 1'b0;
    wait_ready("en_ready_3");
    tick(100);
    check("en_count", oFrameCount, c0 + 16'd3);
    check("en_loads", n_load - l0, 3);
    check("en_ffts", n_fft - f0, 3);
    check("en_idle", oBusy, 1'b0);

    // iLoadComplete is already high and never toggles, so the watchdog fires.
    load_hold = 1'b1; load_resp_en = 1'b0;
    tick(3);
    l0 = n_load; f0 = n_fft; c0 = oFrameCount;
    pulse_host();
    tick(TIMEOUT - 20);
    check("to_no_err_yet", oError, 1'b0);
    check("to_still_busy", oBusy, 1'b1);
    wait_sig("to_err_seen", 2, 60);
    check("to_idle", oBusy, 1'b0);
    check("to_count", oFrameCount, c0);
    check("to_loads", n_load - l0, 1);
    check("to_ffts", n_fft - f0, 0);
    tick(5);
    check("to_err_sticky", oError, 1'b1);
    load_hold = 1'b0; load_resp_en = 1'b1;
    tick(2);
    pulse_host();
    check("to_err_cleared", oError, 1'b0);
    wait_ready("to_recover");
    tick(2);

    // Asynchronous reset in the middle of a scan
    iHostAddr = 10'd9;
    pulse_host();
    wait_sig("rs_scan", 1, FRAME_MAX);
    tick(100);
    #2 iReset = 1'b1;
    #1;
    check("rs_busy", {oHostBusy, oBusy, oFrameReady}, 0);
    check("rs_count", oFrameCount, 0);
    check("rs_peak", oPeakBin, 0);
    check("rs_addr", oFftAddr, 10'd9);
    tick(3);
    iReset = 1'b0;
    tick(2);
    pulse_host();
    wait_ready("rs_next");
    check("rs_next_count", oFrameCount, 16'd1);
    check("rs_next_bin", oPeakBin, 10'd511);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
